// File: rtl/me_ref_row_shifter.sv
// Reference-row shifter: turns one BLK_W+EXTRA pixel row into EXTRA+1 sliding BLK_W windows.
// Define ME_ROW_PREFETCH_EN to add a one-row pending buffer for bubble-free back-to-back rows.
`timescale 1ns/1ps
module me_ref_row_shifter #(
    parameter int PIX_W = 8,
    parameter int BLK_W = 16,
    parameter int EXTRA = 7,
    parameter int ROWS  = 16,
    localparam int ROW_W = (BLK_W + EXTRA) * PIX_W,
    localparam int WIN_W = BLK_W * PIX_W,
    localparam int POS_W = ($clog2(EXTRA + 1) > 1) ? $clog2(EXTRA + 1) : 1,
    localparam int IDX_W = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [ROW_W-1:0] row_i,
    input  logic             row_valid_i,
    output logic             row_ready_o,
    input  logic             flush_i,
    output logic [WIN_W-1:0] win_o,
    output logic             win_valid_o,
    input  logic             win_ready_i,
    output logic [POS_W-1:0] pos_o,
    output logic [IDX_W-1:0] row_idx_o,
    output logic             row_end_o,
    output logic             win_last_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(EXTRA);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS - 1);

    state_t           r_state;
    logic [ROW_W-1:0] r_cur;
    logic [POS_W-1:0] r_pos;
    logic [IDX_W-1:0] r_rowIdx;

    logic             w_rowXfer;
    logic             w_beat;
    logic             w_rowEnd;
    logic             w_nextValid;
    logic [ROW_W-1:0] w_nextRow;

    assign w_rowXfer = row_valid_i && row_ready_o;
    assign w_beat    = (r_state == SHIFT) && win_ready_i;
    assign w_rowEnd  = w_beat && (r_pos == POS_LAST);

`ifdef ME_ROW_PREFETCH_EN
    logic [ROW_W-1:0] r_pend;
    logic             r_pendValid;

    assign row_ready_o = !r_pendValid && !flush_i;

    // A row arriving on the row-end beat bypasses straight into r_cur, so only park it otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend      <= '0;
            r_pendValid <= 1'b0;
        end else if (flush_i) begin
            r_pendValid <= 1'b0;
        end else if (w_rowXfer && (r_state == SHIFT) && !w_rowEnd) begin
            r_pend      <= row_i;
            r_pendValid <= 1'b1;
        end else if (w_rowEnd) begin
            r_pendValid <= 1'b0;
        end
    end

    assign w_nextValid = r_pendValid || w_rowXfer;
    assign w_nextRow   = r_pendValid ? r_pend : row_i;
`else
    assign row_ready_o = (r_state == IDLE) && !flush_i;
    assign w_nextValid = 1'b0;
    assign w_nextRow   = row_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_pos    <= '0;
            r_rowIdx <= '0;
        end else if (flush_i) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_rowIdx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rowXfer) begin
                        r_cur   <= row_i;
                        r_pos   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_rowEnd) begin
                        r_rowIdx <= (r_rowIdx == IDX_LAST) ? '0 : r_rowIdx + 1'b1;
                        r_pos    <= '0;
                        if (w_nextValid) begin
                            r_cur <= w_nextRow;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_beat) begin
                        // Top pixel is zero-filled; it never reaches the window before the row ends.
                        r_cur <= {{PIX_W{1'b0}}, r_cur[ROW_W-1:PIX_W]};
                        r_pos <= r_pos + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign win_o       = r_cur[WIN_W-1:0];
    assign win_valid_o = (r_state == SHIFT);
    assign pos_o       = r_pos;
    assign row_idx_o   = r_rowIdx;
    assign row_end_o   = win_valid_o && (r_pos == POS_LAST);
    assign win_last_o  = row_end_o && (r_rowIdx == IDX_LAST);

endmodule

// File: tb/tb_me_ref_row_shifter.sv
// Self-checking bench for me_ref_row_shifter: directed scenarios plus random traffic against a
// pixel-array reference model (follows ME_ROW_PREFETCH_EN when defined).
`timescale 1ns/1ps
module tb_me_ref_row_shifter;

    localparam int PIX_W  = 8;
    localparam int BLK_W  = 16;
    localparam int EXTRA  = 7;
    localparam int ROWS   = 16;
    localparam int ROWPIX = BLK_W + EXTRA;
    localparam int ROW_W  = ROWPIX * PIX_W;
    localparam int WIN_W  = BLK_W * PIX_W;
`ifdef ME_ROW_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef logic [PIX_W-1:0] pixArr_t [ROWPIX];

    logic             clock = 1'b0;
    logic             resetN;
    logic [ROW_W-1:0] rowIn;
    logic             rowValid;
    logic             rowReady;
    logic             flush;
    logic [WIN_W-1:0] win;
    logic             winValid;
    logic             winReady;
    logic [2:0]       pos;
    logic [3:0]       rowIdx;
    logic             rowEnd;
    logic             winLast;

    int total = 0;
    int bad   = 0;

    // Reference model: current row as a pixel array, offset, row index and a queue of parked rows.
    pixArr_t mRow;
    pixArr_t offer;
    pixArr_t pendQ[$];
    bit      mActive    = 1'b0;
    int      mPos       = 0;
    int      mIdx       = 0;
    bit      haveOffer  = 1'b0;
    bit      patternMode = 1'b0;
    int      xferCount  = 0;

    me_ref_row_shifter #(
        .PIX_W(PIX_W), .BLK_W(BLK_W), .EXTRA(EXTRA), .ROWS(ROWS)
    ) dut (
        .clk_i      (clock),
        .rst_ni     (resetN),
        .row_i      (rowIn),
        .row_valid_i(rowValid),
        .row_ready_o(rowReady),
        .flush_i    (flush),
        .win_o      (win),
        .win_valid_o(winValid),
        .win_ready_i(winReady),
        .pos_o      (pos),
        .row_idx_o  (rowIdx),
        .row_end_o  (rowEnd),
        .win_last_o (winLast)
    );

    always #10 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] expWindow();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int j = 0; j < BLK_W; j++) w[j*PIX_W +: PIX_W] = mRow[mPos + j];
        return w;
    endfunction

    task automatic modelReset();
        mActive = 1'b0;
        mPos    = 0;
        mIdx    = 0;
        pendQ.delete();
    endtask

    // One clock cycle: check state-derived outputs, drive inputs, check ready, advance the model.
    task automatic applyStimulus(input bit rv, input bit wr, input bit fl);
        bit xfer;
        bit used;
        bit expReady;
        @(negedge clock);
        checkOutput("win_valid", winValid, mActive);
        checkOutput("row_idx", rowIdx, mIdx);
        checkOutput("row_end", rowEnd, mActive && (mPos == EXTRA));
        checkOutput("win_last", winLast, mActive && (mPos == EXTRA) && (mIdx == ROWS - 1));
        if (mActive) begin
            checkOutput("pos", pos, mPos);
            checkOutput("win", win, expWindow());
        end
        if (rv && !haveOffer) begin
            for (int k = 0; k < ROWPIX; k++)
                offer[k] = patternMode ? PIX_W'(k) : PIX_W'($urandom_range(0, 255));
            haveOffer = 1'b1;
        end
        for (int k = 0; k < ROWPIX; k++) rowIn[k*PIX_W +: PIX_W] = offer[k];
        rowValid = rv;
        winReady = wr;
        flush    = fl;
        #1;
        expReady = PREFETCH ? (pendQ.size() == 0) && !fl : !mActive && !fl;
        checkOutput("row_ready", rowReady, expReady);
        xfer = rv && expReady;
        used = 1'b0;
        if (fl) begin
            modelReset();
        end else if (!mActive) begin
            if (xfer) begin
                mRow    = offer;
                mPos    = 0;
                mActive = 1'b1;
                used    = 1'b1;
            end
        end else begin
            if (wr) begin
                if (mPos < EXTRA) begin
                    mPos++;
                end else begin
                    mIdx = (mIdx + 1) % ROWS;
                    mPos = 0;
                    if (pendQ.size() > 0) mRow = pendQ.pop_front();
                    else if (xfer) begin
                        mRow = offer;
                        used = 1'b1;
                    end else mActive = 1'b0;
                end
            end
            if (xfer && !used) pendQ.push_back(offer);
        end
        if (xfer) begin
            haveOffer = 1'b0;
            xferCount++;
        end
    endtask

    initial begin
        int cycles;
        int beats;
        int base;
        int n;
        bit rv;
        resetN   = 1'b0;
        rowValid = 1'b0;
        winReady = 1'b0;
        flush    = 1'b0;
        rowIn    = '0;
        #1;
        checkOutput("rst_win", win, 0);
        checkOutput("rst_valid", winValid, 0);
        checkOutput("rst_pos", pos, 0);
        checkOutput("rst_idx", rowIdx, 0);
        checkOutput("rst_end", rowEnd, 0);
        checkOutput("rst_last", winLast, 0);
        checkOutput("rst_ready", rowReady, 1);
        #13 resetN = 1'b1;

        $display("[TB] single row, pixel k = k");
        patternMode = 1'b1;
        applyStimulus(1, 1, 0);
        for (int p = 0; p < 8; p++) begin
            applyStimulus(0, 1, 0);
            checkOutput("sr_pix0", win[7:0], p);
            checkOutput("sr_pix15", win[127:120], p + 15);
            checkOutput("sr_pos", pos, p);
            checkOutput("sr_end", rowEnd, (p == 7));
        end
        applyStimulus(0, 1, 0);
        checkOutput("sr_idle", winValid, 0);
        checkOutput("sr_idx", rowIdx, 1);

        $display("[TB] backpressure at pos 4");
        applyStimulus(1, 1, 0);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, !(c >= 5 && c <= 7), 0);
            if (c >= 5 && c <= 8) begin
                checkOutput("bp_pix0", win[7:0], 8'h04);
                checkOutput("bp_pos", pos, 4);
            end
            if (c == 9) checkOutput("bp_next", pos, 5);
        end
        n = 0;
        while (mActive && n < 20) begin
            applyStimulus(0, 1, 0);
            n++;
        end
        patternMode = 1'b0;

        $display("[TB] 16 back-to-back rows");
        applyStimulus(0, 0, 1);
        base   = xferCount;
        cycles = 0;
        beats  = 0;
        while (beats < 128 && cycles < 400) begin
            rv = (xferCount - base) < 16;
            applyStimulus(rv, 1, 0);
            cycles++;
            if (winValid) begin
                beats++;
                if (beats == 128) begin
                    checkOutput("bb_last", winLast, 1);
                    checkOutput("bb_idx15", rowIdx, 15);
                end
            end
        end
        checkOutput("bb_cycles", cycles, PREFETCH ? 129 : 144);
        applyStimulus(0, 1, 0);
        checkOutput("bb_wrap", rowIdx, 0);

        $display("[TB] flush at pos 3 of row 2");
        n = 0;
        while (!(mActive && mIdx == 2 && mPos == 3) && n < 100) begin
            applyStimulus(1, 1, 0);
            n++;
        end
        checkOutput("fl_reach", n < 100, 1);
        applyStimulus(1, 1, 1);
        checkOutput("fl_ready", rowReady, 0);
        applyStimulus(0, 0, 0);
        checkOutput("fl_valid", winValid, 0);
        checkOutput("fl_idx", rowIdx, 0);
        applyStimulus(0, 1, 0);
        checkOutput("fl_nopend", winValid, 0);

        $display("[TB] async reset mid-row");
        applyStimulus(1, 1, 0);
        for (int c = 0; c < 3; c++) applyStimulus(0, 1, 0);
        #2 resetN = 1'b0;
        #2;
        checkOutput("ar_win", win, 0);
        checkOutput("ar_valid", winValid, 0);
        checkOutput("ar_pos", pos, 0);
        checkOutput("ar_idx", rowIdx, 0);
        checkOutput("ar_end", rowEnd, 0);
        checkOutput("ar_last", winLast, 0);
        modelReset();
        #2 resetN = 1'b1;
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("ar_pos0", pos, 0);
        checkOutput("ar_idx0", rowIdx, 0);
        checkOutput("ar_restart", winValid, 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            rv = haveOffer ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_ref_row_shifter.md
# me_ref_row_shifter

Parametrised reference-row shifter for the motion-estimation datapath. It accepts one search-area row of `BLK_W+EXTRA` pixels and emits `EXTRA+1` horizontal candidate windows of `BLK_W` pixels, one per accepted beat, shifting one pixel per beat. It sits between the reference-row fetch and the SAD array, and generalises the fixed 16+7-pixel row split with parameters, valid/ready handshakes, row counting and optional row prefetch.

## Interface
- `PIX_W`, 8, bits per pixel
- `BLK_W`, 16, pixels per candidate window (≥1)
- `EXTRA`, 7, extra pixels per row; candidate offsets 0..EXTRA (≥1)
- `ROWS`, 16, rows per search block, used for row index and last flag (≥2)
- `clk_i` in 1: the single clock; all logic is on its rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `row_i` in `(BLK_W+EXTRA)*PIX_W`: pixel k at bits `[k*PIX_W +: PIX_W]`; pixel 0 is leftmost
- `row_valid_i` in 1, `row_ready_o` out 1: row handshake; transfer when both are high
- `flush_i` in 1: synchronous abort
- `win_o` out `BLK_W*PIX_W`: window pixels `pos..pos+BLK_W-1`, same packing as `row_i`
- `win_valid_o` out 1, `win_ready_i` in 1: window handshake; beat when both are high
- `pos_o` out `max(1,$clog2(EXTRA+1))`: horizontal offset of `win_o`
- `row_idx_o` out `max(1,$clog2(ROWS))`: row index within the block
- `row_end_o` out 1: `win_valid_o && pos_o==EXTRA`
- `win_last_o` out 1: `row_end_o && row_idx_o==ROWS-1`

## Operation
- State: `cur` shift register of `BLK_W+EXTRA` pixels, with `pos` and `row_idx` counters. FSM states are IDLE and SHIFT.
- `win_o` is the low `BLK_W` pixels of `cur`, driven from registers.
- IDLE:
  - `win_valid_o=0`.
  - On a row transfer: load `cur`, set `pos=0`, go to SHIFT.
- SHIFT:
  - `win_valid_o=1`.
  - On a beat with `pos<EXTRA`: shift `cur` right by `PIX_W` (zero-fill the top pixel) and increment `pos`.
  - On a beat with `pos==EXTRA` (row end):
    - `row_idx` increments, wrapping from `ROWS-1` to 0.
    - If a next row is available (see Configuration), load it and set `pos=0`, staying in SHIFT.
    - Otherwise go to IDLE.
- Without a beat, all state holds. `win_o`, `pos_o` and `row_idx_o` stay stable while `win_valid_o && !win_ready_i`.
- `flush_i`:
  - Has priority over all other events.
  - Forces `row_ready_o=0` in the same cycle, so no row is accepted.
  - Next cycle: IDLE, `pos=0`, `row_idx=0`, and any pending row is discarded.
- `row_valid_i` must hold `row_i` stable until the transfer. Rows are never reordered or dropped except by flush or reset.

## Timing
- Reset (async assert):
  - `win_valid_o=0`, `win_o=0`, `pos_o=0`, `row_idx_o=0`, `row_end_o=0`, `win_last_o=0`; state IDLE; pending row empty.
  - `row_ready_o` reads 1 after reset, but no transfer occurs while `rst_ni=0`.
- Reset mid-row: all progress is lost and outputs are immediately at reset values.
- Latency: a row accepted at edge N gives `win_valid_o=1` with `pos_o=0` after edge N; the first window is available in the cycle following acceptance.
- Full rate with `win_ready_i=1`:
  - Without prefetch: `EXTRA+1` beats per row plus 1 IDLE cycle, i.e. 9 cycles per row at defaults.
  - With prefetch: `EXTRA+1` cycles per row, i.e. 8 cycles at defaults, with no bubble.
- Simultaneous row transfer and last beat, prefetch enabled and pending empty: the new row bypasses into `cur` and `pos=0` on that edge.

## Configuration
- Macro: `ME_ROW_PREFETCH_EN`.
- Defined:
  - Adds a one-row pending register; `row_ready_o = !pend_valid && !flush_i`.
  - A row accepted during SHIFT goes to pending, and loads into `cur` on the row-end beat.
  - In IDLE, or with the bypass case above, the row goes directly to `cur`.
- Undefined:
  - No pending register; `row_ready_o = (state==IDLE) && !flush_i`.
  - Each row end returns to IDLE for at least one cycle.

## Test plan
- **Single row, defaults, `win_ready_i=1`.** Present `row_i` with pixel k = k (0x00..0x16).
  - Expect 8 beats: beat p has `win_o` pixel0 = p and pixel15 = p+15, `pos_o=p`.
  - `row_end_o=1` on beat 7 only; `row_idx_o` then 1; FSM returns to IDLE.
- **Backpressure.** Drop `win_ready_i` for 3 cycles at `pos_o=4`.
  - `win_o` pixel0 holds 0x04 and `pos_o` holds 4; the next accepted beat is pos 5.
- **16 back-to-back rows, prefetch defined.**
  - 128 beats in 128 consecutive cycles.
  - `win_last_o=1` only on beat 127, with `row_idx_o=15`; `row_idx_o` then wraps to 0.
- **Same 16 rows, prefetch undefined.**
  - 144 cycles total; `row_ready_o=0` throughout SHIFT.
- **Flush at `pos_o=3` of row 2, with `row_valid_i=1`.**
  - No row is accepted that cycle; next cycle `win_valid_o=0`, `row_idx_o=0`, and any pending row is gone.
- **Async reset mid-row.** Pulse `rst_ni=0` between edges.
  - All outputs go to 0 immediately; the next row restarts at `pos_o=0`, `row_idx_o=0`.
